segment_transition_scheduler: RTL and testbench

- Sequences the active-segment switch for the STM or modulation datapath: accepts a transition request from the controller, waits for the requested trigger condition, then swaps the segment aligned to the datapath UPDATE strobe.
- Two instances are used, one per datapath (STM, modulation). Each sits between the controller settings and the STM/modulation segment selects.
- Centralises the immediate, index-wrap, system-time and GPIO transition rules, so the datapaths only consume a registered SEGMENT value.

---
 rtl/segment_transition_scheduler.sv | 145 ++++++++++++++
 tb/tb_segment_transition_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/segment_transition_scheduler.sv
// Active-segment switch sequencer: captures a transition request, waits for its
// trigger (immediate, index wrap, system time or GPIO edge), then commits on UPDATE.
module segment_transition_scheduler #(
    parameter int TIME_W      = 64,
    parameter int GPIO_N      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_segment,
    input  logic [2:0]        req_mode,
    input  logic [TIME_W-1:0] req_value,
    input  logic              update,
    input  logic              idx_wrap,
    input  logic [TIME_W-1:0] sys_time,
    input  logic [GPIO_N-1:0] gpio_in,
    output logic              segment,
    output logic              swap,
    output logic              busy,
    output logic              err
);

    localparam int PIN_W = (GPIO_N > 1) ? $clog2(GPIO_N) : 1;

    localparam logic [2:0] MODE_IMM  = 3'd0;
    localparam logic [2:0] MODE_IDX  = 3'd1;
    localparam logic [2:0] MODE_TIME = 3'd2;
    localparam logic [2:0] MODE_GPIO = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT
    } state_t;

    state_t              state;
    logic                seg_q;
    logic [2:0]          mode_q;
    logic [TIME_W-1:0]   value_q;
    logic [PIN_W-1:0]    pin_q;
    logic [GPIO_N-1:0]   sync_q [SYNC_STAGES];
    logic [GPIO_N-1:0]   gpio_prev;
    logic [GPIO_N-1:0]   gpio_rise;
    logic                trig_hit;

    assign req_ready = 1'b1;

    // Edge history runs continuously so an edge seen while idle is consumed, not stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            gpio_prev <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            gpio_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign gpio_rise = sync_q[SYNC_STAGES-1] & ~gpio_prev;

    always_comb begin
        trig_hit = 1'b0;
        case (mode_q)
            MODE_IDX:  trig_hit = idx_wrap;
            MODE_TIME: trig_hit = (sys_time >= value_q);
            MODE_GPIO: trig_hit = gpio_rise[pin_q];
            default:   trig_hit = 1'b0;
        endcase
    end

    // A new request always takes priority over whatever is pending, including a
    // trigger or UPDATE arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            seg_q   <= 1'b0;
            mode_q  <= MODE_IMM;
            value_q <= '0;
            pin_q   <= '0;
            segment <= 1'b0;
            swap    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            swap <= 1'b0;
            err  <= 1'b0;
            if (req_valid) begin
                seg_q   <= req_segment;
                mode_q  <= req_mode;
                value_q <= req_value;
                pin_q   <= req_value[PIN_W-1:0];
                case (req_mode)
                    MODE_IMM: begin
                        state <= COMMIT;
                        busy  <= 1'b0;
                    end
                    MODE_IDX, MODE_GPIO: begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                    MODE_TIME: begin
                        busy <= 1'b1;
                        // A trigger time already in the past still commits, but is flagged.
                        if (req_value < sys_time) begin
                            err   <= 1'b1;
                            state <= COMMIT;
                        end else begin
                            state <= ARMED;
                        end
                    end
                    default: begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else begin
                case (state)
                    ARMED: begin
                        if (trig_hit) begin
                            state <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        if (update) begin
                            segment <= seg_q;
                            swap    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_segment_transition_scheduler.sv
// Directed bench for segment_transition_scheduler: cycle table plus hand-written
// sequences for asynchronous reset and GPIO synchroniser latency.
module tb_segment_transition_scheduler;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_segment;
    logic [2:0]  req_mode;
    logic [63:0] req_value;
    logic        update;
    logic        idx_wrap;
    logic [63:0] sys_time;
    logic [3:0]  gpio_in;
    logic        segment;
    logic        swap;
    logic        busy;
    logic        err;

    int checks;
    int failures;

    segment_transition_scheduler #(
        .TIME_W(64),
        .GPIO_N(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_segment(req_segment),
        .req_mode(req_mode),
        .req_value(req_value),
        .update(update),
        .idx_wrap(idx_wrap),
        .sys_time(sys_time),
        .gpio_in(gpio_in),
        .segment(segment),
        .swap(swap),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle of inputs; exp = {segment, swap, busy, err} after that edge.
    typedef struct {
        logic        v;
        logic [2:0]  m;
        logic        s;
        logic [63:0] val;
        logic        upd;
        logic        wrap;
        logic [63:0] t;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [2:0] m, input logic s,
                                input logic [63:0] val, input logic upd, input logic wrap,
                                input logic [63:0] t, input logic [3:0] e);
        vec_t r;
        r.v = v; r.m = m; r.s = s; r.val = val;
        r.upd = upd; r.wrap = wrap; r.t = t; r.exp = e;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t r);
        req_valid   = r.v;
        req_mode    = r.m;
        req_segment = r.s;
        req_value   = r.val;
        update      = r.upd;
        idx_wrap    = r.wrap;
        sys_time    = r.t;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req_valid   = 1'b0;
        req_mode    = 3'd0;
        req_segment = 1'b0;
        req_value   = '0;
        update      = 1'b0;
        idx_wrap    = 1'b0;
        sys_time    = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        gpio_in  = 4'b0;
        clearInputs();

        step();
        step();
        checkOutput("reset_outputs", {4'b0, segment, swap, busy, err}, 8'h00);
        checkOutput("reset_ready", {7'b0, req_ready}, 8'h01);
        rst_n = 1'b1;

        //                v  mode  seg val    upd wrap time   exp
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 0, 0,    4'b0000));
        vecs.push_back(mk(1, 3'd0, 1, 0,     0, 0, 0,    4'b0000));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 0, 0,    4'b0000));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1100));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 0, 0,    4'b1000));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1000));
        vecs.push_back(mk(1, 3'd1, 0, 0,     0, 0, 0,    4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 1, 0,    4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 0, 0,    4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b0100));
        vecs.push_back(mk(1, 3'd1, 1, 0,     0, 0, 0,    4'b0010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 1, 0,    4'b0010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1100));
        vecs.push_back(mk(1, 3'd2, 0, 1000,  0, 0, 900,  4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 990,  4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 1000, 4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 1010, 4'b0100));
        vecs.push_back(mk(1, 3'd2, 1, 5,     0, 0, 900,  4'b0011));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 0, 910,  4'b0010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 920,  4'b1100));
        vecs.push_back(mk(1, 3'd2, 1, 100,   0, 0, 100,  4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 0, 100,  4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 100,  4'b1100));
        vecs.push_back(mk(1, 3'd1, 0, 0,     0, 0, 0,    4'b1010));
        vecs.push_back(mk(1, 3'd0, 1, 0,     0, 0, 0,    4'b1000));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 1, 0,    4'b1000));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1100));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1000));
        vecs.push_back(mk(1, 3'd0, 0, 0,     0, 0, 0,    4'b1000));
        vecs.push_back(mk(1, 3'd1, 0, 0,     1, 0, 0,    4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1010));
        vecs.push_back(mk(1, 3'd5, 0, 0,     0, 0, 0,    4'b1001));
        vecs.push_back(mk(0, 3'd0, 0, 0,     0, 1, 0,    4'b1000));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1000));
        vecs.push_back(mk(1, 3'd1, 0, 0,     0, 0, 0,    4'b1010));
        vecs.push_back(mk(0, 3'd0, 0, 0,     1, 0, 0,    4'b1010));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d", i), {4'b0, segment, swap, busy, err}, {4'b0, vecs[i].exp});
        end
        clearInputs();

        // Asynchronous reset while ARMED: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {4'b0, segment, swap, busy, err}, 8'h00);
        checkOutput("async_reset_ready", {7'b0, req_ready}, 8'h01);
        step();
        rst_n = 1'b1;
        idx_wrap = 1'b1;
        step();
        idx_wrap = 1'b0;
        update = 1'b1;
        step();
        update = 1'b0;
        checkOutput("post_reset_no_swap", {5'b0, segment, swap, busy}, 8'h00);

        // GPIO mode on pin 2; a glitch on pin 1 must be ignored.
        req_valid = 1'b1; req_mode = 3'd3; req_segment = 1'b1; req_value = 64'd2;
        step();
        clearInputs();
        checkOutput("gpio_armed", {5'b0, segment, swap, busy}, 8'h01);
        gpio_in = 4'b0010;
        step();
        gpio_in = 4'b0000;
        step(); step(); step();
        update = 1'b1;
        step();
        update = 1'b0;
        checkOutput("gpio_glitch_ignored", {5'b0, segment, swap, busy}, 8'h01);

        gpio_in = 4'b0100;
        step();
        step();
        update = 1'b1;
        step();
        checkOutput("gpio_trig_same_update", {5'b0, segment, swap, busy}, 8'h01);
        step();
        update = 1'b0;
        checkOutput("gpio_commit", {5'b0, segment, swap, busy}, 8'h06);
        step();
        checkOutput("gpio_swap_one_cycle", {5'b0, segment, swap, busy}, 8'h04);

        // An edge seen while idle must not arm a later GPIO request.
        gpio_in = 4'b0000;
        step(); step(); step();
        gpio_in = 4'b0100;
        step(); step(); step(); step();
        req_valid = 1'b1; req_mode = 3'd3; req_segment = 1'b0; req_value = 64'd2;
        step();
        clearInputs();
        step(); step(); step();
        update = 1'b1;
        step();
        step();
        update = 1'b0;
        checkOutput("gpio_idle_edge_ignored", {5'b0, segment, swap, busy}, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
